// File: rtl/rom_streamer.sv
// rom_streamer: burst read sequencer for a synchronous ROM with a 1-cycle registered read.
// A start pulse in idle launches a burst of len_i words from start_addr_i. Each returned word
// is presented on a valid/ready stream. A 2-entry FIFO absorbs the ROM latency and any
// downstream backpressure.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                1-cycle burst request, sampled only in idle
//   start_addr_i, len_i    first address and word count (0 .. 2**ADDR_WIDTH)
//   rom_addr_o, rom_q_i    ROM address (registered) and returned word
//   out_data_o/valid/ready output stream (FIFO head)
//   busy_o, done_o         burst in progress / 1-cycle completion pulse
module rom_streamer #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_q_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [ADDR_WIDTH:0]   CntOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] AddrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH:0]   xfer_cnt_q, xfer_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;

  logic       pop, push, issue, accept;
  logic [2:0] occ;

  assign pop    = (cnt_q != 2'd0) && out_ready_i;
  assign push   = inflight_q;
  // Occupancy after this edge's pop, counting the read still in the ROM pipeline.
  assign occ    = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue  = (state_q == StRun) && (occ < 3'd2);
  assign accept = (state_q == StIdle) && start_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = (len_i == '0) ? StDone : StRun;
      StRun:   if (issue && issue_cnt_q == CntOne) state_d = StDrain;
      StDrain: if (pop && xfer_cnt_q == CntOne) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    inflight_d  = issue;
    if (accept && len_i != '0) begin
      addr_d      = start_addr_i;
      issue_cnt_d = len_i;
      xfer_cnt_d  = len_i;
    end
    if (issue) begin
      addr_d      = addr_q + AddrOne;
      issue_cnt_d = issue_cnt_q - CntOne;
    end
    if (pop) begin
      xfer_cnt_d = xfer_cnt_q - CntOne;
    end
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      issue_cnt_q <= '0;
      xfer_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      // rom_q_i reflects the address sampled on the previous edge, i.e. the issued read.
      if (push) fifo_q[wr_ptr_q] <= rom_q_i;
    end
  end

  // Outputs
  always_comb begin
    rom_addr_o  = addr_q;
    out_valid_o = (cnt_q != 2'd0);
    out_data_o  = fifo_q[rd_ptr_q];
    busy_o      = (state_q == StRun) || (state_q == StDrain);
    done_o      = (state_q == StDone);
  end

endmodule

// File: tb/tb_rom_streamer.sv
// tb_rom_streamer: directed bench for rom_streamer with an 8-bit ROM model mem[i] = i*0x01010101.
module tb_rom_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_addr = 8'h00;
  logic [8:0]  len = 9'd0;
  logic [7:0]  rom_addr;
  logic [31:0] rom_q;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rom_streamer #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .start_addr_i(start_addr),
    .len_i       (len),
    .rom_addr_o  (rom_addr),
    .rom_q_i     (rom_q),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .done_o      (done)
  );

  // Synchronous ROM: i*0x01010101 for an 8-bit i is i replicated four times.
  always_ff @(posedge clk) rom_q <= {4{rom_addr}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] a, input logic [8:0] n);
    start      = 1'b1;
    start_addr = a;
    len        = n;
    step();
    start = 1'b0;
  endtask

  // Called right after the start edge E0. stall: ready pattern 1,0,0 repeating.
  // inject: a competing start (0x80, len 2) at cycle 3, which must be ignored.
  task automatic collect(input logic [7:0] sa, input int n, input bit stall, input bit inject);
    int          got = 0;
    int          cyc = 0;
    int          first = -1;
    int          last = -1;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [7:0]  w;
    logic [7:0]  ahead;
    while (got < n && cyc < 100) begin
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (inject) begin
        start      = (cyc == 3);
        start_addr = 8'h80;
        len        = 9'd2;
      end
      if (!stall) chk("rom_addr_seq", {24'b0, rom_addr}, {24'b0, sa + 8'(cyc < n ? cyc : n)});
      if (stall) begin
        ahead = rom_addr - sa - 8'(got);
        chk("addr_ahead_le2", 32'(ahead <= 8'd2), 32'd1);
      end
      if (prev_stall) chk("data_hold", out_data, prev_data);
      if (out_valid && first < 0) first = cyc;
      if (out_valid && out_ready) begin
        w = sa + 8'(got);
        chk("data_order", out_data, {4{w}});
        got++;
        last = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      step();
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("word_count", 32'(got), 32'(n));
    if (!stall) begin
      chk("first_valid_cyc", 32'(first), 32'd2);
      chk("last_xfer_cyc", 32'(last), 32'(n + 1));
    end
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("busy_in_done", {31'b0, busy}, 32'd0);
    chk("valid_in_done", {31'b0, out_valid}, 32'd0);
    step();
    chk("done_clear", {31'b0, done}, 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_rom_addr", {24'b0, rom_addr}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: basic burst, full throughput
    launch(8'h10, 9'd4);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    collect(8'h10, 4, 1'b0, 1'b0);

    // 2: same burst with backpressure
    launch(8'h10, 9'd4);
    collect(8'h10, 4, 1'b1, 1'b0);

    // 3: address wrap FE,FF,00,01
    launch(8'hFE, 9'd4);
    collect(8'hFE, 4, 1'b0, 1'b0);

    // 4: zero-length burst
    launch(8'h55, 9'd0);
    chk("t4_done", {31'b0, done}, 32'd1);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("t4_done_clear", {31'b0, done}, 32'd0);
    chk("t4_valid2", {31'b0, out_valid}, 32'd0);

    // 5: start while busy is ignored
    launch(8'h40, 9'd8);
    collect(8'h40, 8, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_extra_valid", {31'b0, out_valid}, 32'd0);
      chk("t5_no_extra_busy", {31'b0, busy}, 32'd0);
      step();
    end

    // 6: reset during the third transfer
    launch(8'h20, 9'd8);
    repeat (4) step();
    chk("t6_third_word", out_data, 32'h20202020 + 32'h02020202);
    chk("t6_third_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_rom_addr", {24'b0, rom_addr}, 32'd0);
    chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_data", out_data, 32'd0);
    chk("t6_rst_busy", {31'b0, busy}, 32'd0);
    chk("t6_rst_done", {31'b0, done}, 32'd0);
    step();
    step();
    chk("t6_no_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("t6_idle_after_rel", {31'b0, busy | done | out_valid}, 32'd0);
    launch(8'h30, 9'd3);
    collect(8'h30, 3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
